// File: rtl/zeroriscy_data_arbiter.sv
// ----------------------------------------------------------------------------
// zeroriscy_data_arbiter
//
// Shares one pipelined data-bus slave between two masters: the core LSU (m0)
// and a debug/DMA master (m1). The address phase is muxed combinationally.
// Response ownership is tracked in an in-order owner FIFO of depth
// MAX_OUTSTANDING, so every slave response is steered back to the master
// that issued the matching request.
//
// Configuration macro:
//   ZERORISCY_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                        undefined -> fixed priority, m0 always wins
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_* / m1_*                master request side: req/addr/we/be/wdata in,
//                              gnt/rvalid out
//   m_rdata_o                  shared read data (straight from the slave)
//   s_req_o .. s_wdata_o       slave address phase
//   s_gnt_i, s_rvalid_i,
//   s_rdata_i                  slave grant and response
//   err_unexp_o                sticky: response seen with nothing outstanding
//
// Handshake: a slave transaction is accepted in any cycle where
// s_req_o && s_gnt_i; the matching master sees mN_gnt_o in that same cycle.
// Responses return in order, one per s_rvalid_i cycle. Masters keep their
// request stable until granted.
// ----------------------------------------------------------------------------
module zeroriscy_data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m0_we_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m_rdata_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        err_unexp_o
);

  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] PTR_LAST = 2'(MAX_OUTSTANDING - 1);

  // Owner FIFO: 0 = m0, 1 = m1. Storage is sized for the largest legal
  // depth; pointers wrap at MAX_OUTSTANDING so unused entries are never hit.
  logic       owner_q [4];
  logic [1:0] wptr_q;
  logic [1:0] rptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;

  // Selection hold: set when the slave saw a request but did not grant it.
  logic       hold_q;
  logic       hold_id_q;
  logic       err_q;

`ifdef ZERORISCY_ARB_RR_EN
  logic       last_q;   // last granted master, 1 = m1
`endif

  logic can_issue;
  logic arb_id;
  logic sel_id;
  logic push;
  logic pop;
  logic head_id;
  logic held_req;

  assign can_issue = (count_q < MAX_CNT);
  assign held_req  = hold_id_q ? m1_req_i : m0_req_i;

  always_comb begin
    arb_id = 1'b0;
    if (hold_q && held_req) begin
      // An ungranted request keeps its slot regardless of priority.
      arb_id = hold_id_q;
    end else if (m0_req_i && m1_req_i) begin
`ifdef ZERORISCY_ARB_RR_EN
      arb_id = ~last_q;
`else
      arb_id = 1'b0;
`endif
    end else begin
      arb_id = m1_req_i;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign s_req_o = rst_n & can_issue & (m0_req_i | m1_req_i);
  assign sel_id  = s_req_o & arb_id;

  assign s_addr_o  = sel_id ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel_id ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel_id ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel_id ? m1_wdata_i : m0_wdata_i;

  assign push     = s_req_o & s_gnt_i;
  assign m0_gnt_o = push & ~sel_id;
  assign m1_gnt_o = push &  sel_id;

  // Responses with nothing outstanding are not popped; they only flag error.
  assign pop         = s_rvalid_i & (count_q != 3'd0);
  assign head_id     = owner_q[rptr_q];
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop &  head_id;
  assign m_rdata_o   = s_rdata_i;
  assign err_unexp_o = err_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) owner_q[i] <= 1'b0;
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
      count_q   <= 3'd0;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef ZERORISCY_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      if (push) begin
        owner_q[wptr_q] <= sel_id;
        wptr_q          <= (wptr_q == PTR_LAST) ? 2'd0 : wptr_q + 2'd1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PTR_LAST) ? 2'd0 : rptr_q + 2'd1;
      end
      count_q   <= count_d;
      hold_q    <= s_req_o & ~s_gnt_i;
      hold_id_q <= sel_id;
      if (s_rvalid_i && (count_q == 3'd0)) begin
        err_q <= 1'b1;
      end
`ifdef ZERORISCY_ARB_RR_EN
      if (push) begin
        last_q <= sel_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_zeroriscy_data_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for zeroriscy_data_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based model of
// the arbiter's rules.
// ----------------------------------------------------------------------------
module tb_zeroriscy_data_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m1_req_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        err_unexp_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [0:0] exp_q[$];   // owners of outstanding transactions, oldest first
  int         hold_m;     // master waiting for grant, -1 if none
  logic       last_m;     // last granted master
  logic       err_m;

  // Expectations of the current cycle (computed in probe, applied in tick)
  logic       e_sreq, e_pick, e_gnt0, e_gnt1;

  zeroriscy_data_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
    .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
    .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
    .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
    .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
    .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .err_unexp_o(err_unexp_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_m = -1;
    last_m = 1'b1;
    err_m  = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
  endtask

  // Mid-cycle: derive expected outputs from the current inputs and model.
  task automatic probe();
    int   sz;
    logic pop_ok;
    logic head;
    logic sel;
    #3;
    sz     = exp_q.size();
    head   = (sz > 0) ? exp_q[0] : 1'b0;
    e_pick = 1'b0;
    if (hold_m == 0 && m0_req_i)       e_pick = 1'b0;
    else if (hold_m == 1 && m1_req_i)  e_pick = 1'b1;
    else if (m0_req_i && m1_req_i) begin
`ifdef ZERORISCY_ARB_RR_EN
      e_pick = (last_m == 1'b0) ? 1'b1 : 1'b0;
`else
      e_pick = 1'b0;
`endif
    end else if (m1_req_i)             e_pick = 1'b1;
    e_sreq = rst_n && (sz < MAX) && (m0_req_i || m1_req_i);
    e_gnt0 = e_sreq && s_gnt_i && (e_pick == 1'b0);
    e_gnt1 = e_sreq && s_gnt_i && (e_pick == 1'b1);
    sel    = e_sreq && e_pick;
    pop_ok = rst_n && s_rvalid_i && (sz > 0);
    chk("s_req",   {31'd0, s_req_o},    {31'd0, e_sreq});
    chk("s_addr",  s_addr_o,            sel ? m1_addr_i : m0_addr_i);
    chk("s_we",    {31'd0, s_we_o},     {31'd0, sel ? m1_we_i : m0_we_i});
    chk("s_be",    {28'd0, s_be_o},     {28'd0, sel ? m1_be_i : m0_be_i});
    chk("s_wdata", s_wdata_o,           sel ? m1_wdata_i : m0_wdata_i);
    chk("m0_gnt",  {31'd0, m0_gnt_o},   {31'd0, e_gnt0});
    chk("m1_gnt",  {31'd0, m1_gnt_o},   {31'd0, e_gnt1});
    chk("m0_rvld", {31'd0, m0_rvalid_o}, {31'd0, pop_ok && head == 1'b0});
    chk("m1_rvld", {31'd0, m1_rvalid_o}, {31'd0, pop_ok && head == 1'b1});
    chk("m_rdata", m_rdata_o,           s_rdata_i);
    chk("err",     {31'd0, err_unexp_o}, {31'd0, err_m});
  endtask

  // Clock edge: advance the model, then move just past the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (s_rvalid_i) begin
        if (exp_q.size() == 0) err_m = 1'b1;
        else void'(exp_q.pop_front());
      end
      if (e_gnt0 || e_gnt1) begin
        exp_q.push_back(e_pick);
        last_m = e_pick;
      end
      hold_m = (e_sreq && !s_gnt_i) ? int'(e_pick) : -1;
    end
    #1;
  endtask

  task automatic drive_rand();
    if (!(m0_req_i && !e_gnt0)) begin
      m0_req_i   = 1'($urandom_range(0, 1));
      m0_addr_i  = $urandom;
      m0_we_i    = 1'($urandom_range(0, 1));
      m0_be_i    = 4'($urandom_range(0, 15));
      m0_wdata_i = $urandom;
    end
    if (!(m1_req_i && !e_gnt1)) begin
      m1_req_i   = 1'($urandom_range(0, 1));
      m1_addr_i  = $urandom;
      m1_we_i    = 1'($urandom_range(0, 1));
      m1_be_i    = 4'($urandom_range(0, 15));
      m1_wdata_i = $urandom;
    end
    s_gnt_i    = 1'($urandom_range(0, 1));
    s_rvalid_i = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    s_rdata_i  = $urandom;
  endtask

  initial begin
    // Reset with active inputs: grants and responses must stay quiet
    m0_req_i = 1'b1; m1_req_i = 1'b0;
    m0_addr_i = 32'h0; m1_addr_i = 32'h0;
    m0_we_i = 1'b0; m1_we_i = 1'b0; m0_be_i = 4'hf; m1_be_i = 4'hf;
    m0_wdata_i = 32'h0; m1_wdata_i = 32'h0;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h0;
    e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_sreq = 1'b0; e_pick = 1'b0;
    assert_reset();
    #1;
    probe();
    chk("rst_m0_gnt", {31'd0, m0_gnt_o}, 32'd0);
    chk("rst_m0_rvld", {31'd0, m0_rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, err_unexp_o}, 32'd0);
    tick();
    probe(); tick();
    m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    rst_n = 1'b1;

    // Single m0 read, response two cycles after grant
    m0_req_i = 1'b1; m0_addr_i = 32'h100; m0_we_i = 1'b0; s_gnt_i = 1'b1;
    probe();
    chk("rd_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    chk("rd_addr", s_addr_o, 32'h100);
    tick();
    m0_req_i = 1'b0; s_gnt_i = 1'b0;
    probe(); chk("rd_gnt_once", {31'd0, m0_gnt_o}, 32'd0); tick();
    s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    probe();
    chk("rd_m0_rvld", {31'd0, m0_rvalid_o}, 32'd1);
    chk("rd_m1_rvld", {31'd0, m1_rvalid_o}, 32'd0);
    chk("rd_rdata", m_rdata_o, 32'hDEADBEEF);
    tick();
    s_rvalid_i = 1'b0;

    // Continuous contention, response one cycle after each grant
    assert_reset(); probe(); tick(); rst_n = 1'b1;
    m0_req_i = 1'b1; m0_addr_i = 32'hA0; m1_req_i = 1'b1; m1_addr_i = 32'hB0;
    s_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_rvalid_i = (i > 0);
      probe();
`ifdef ZERORISCY_ARB_RR_EN
      chk("cont_m0_gnt", {31'd0, m0_gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_m1_gnt", {31'd0, m1_gnt_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
`else
      chk("cont_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
      chk("cont_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
`endif
      tick();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    probe(); tick();
    s_rvalid_i = 1'b0;

    // Held selection: m1 waits three cycles while m0 raises its request
    m1_req_i = 1'b1; m1_addr_i = 32'h2000; s_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin m0_req_i = 1'b1; m0_addr_i = 32'h1000; end
      probe();
      chk("hold_addr", s_addr_o, 32'h2000);
      chk("hold_m0_gnt", {31'd0, m0_gnt_o}, 32'd0);
      tick();
    end
    s_gnt_i = 1'b1;
    probe(); chk("hold_m1_gnt", {31'd0, m1_gnt_o}, 32'd1); tick();
    m1_req_i = 1'b0;
    probe();
    chk("hold_m0_after", {31'd0, m0_gnt_o}, 32'd1);
    chk("hold_m0_addr", s_addr_o, 32'h1000);
    tick();
    m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    probe(); chk("hold_rsp1", {31'd0, m1_rvalid_o}, 32'd1); tick();
    probe(); chk("hold_rsp0", {31'd0, m0_rvalid_o}, 32'd1); tick();
    s_rvalid_i = 1'b0;

    // Outstanding limit, no bypass on the freeing response
    m0_req_i = 1'b1; m0_addr_i = 32'h300; s_gnt_i = 1'b1;
    for (int i = 0; i < MAX; i++) begin
      probe(); chk("lim_fill_gnt", {31'd0, m0_gnt_o}, 32'd1); tick();
    end
    probe(); chk("lim_full_req", {31'd0, s_req_o}, 32'd0); tick();
    s_rvalid_i = 1'b1;
    probe();
    chk("lim_nobypass", {31'd0, s_req_o}, 32'd0);
    chk("lim_rvld", {31'd0, m0_rvalid_o}, 32'd1);
    tick();
    s_rvalid_i = 1'b0;
    probe(); chk("lim_resume", {31'd0, m0_gnt_o}, 32'd1); tick();
    m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    for (int i = 0; i < MAX; i++) begin probe(); tick(); end
    s_rvalid_i = 1'b0;

    // In-order responses with push and pop in the same cycle
    m0_req_i = 1'b1; s_gnt_i = 1'b1;
    probe(); chk("ord_m0_gnt", {31'd0, m0_gnt_o}, 32'd1); tick();
    m0_req_i = 1'b0; m1_req_i = 1'b1; s_rvalid_i = 1'b1;
    probe();
    chk("ord_m1_gnt", {31'd0, m1_gnt_o}, 32'd1);
    chk("ord_m0_rvld", {31'd0, m0_rvalid_o}, 32'd1);
    tick();
    m1_req_i = 1'b0; s_gnt_i = 1'b0;
    probe();
    chk("ord_m1_rvld", {31'd0, m1_rvalid_o}, 32'd1);
    chk("ord_m0_quiet", {31'd0, m0_rvalid_o}, 32'd0);
    tick();

    // Unexpected response: sticky error until reset
    probe();
    chk("unexp_no_rvld", {31'd0, m0_rvalid_o | m1_rvalid_o}, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe(); chk("unexp_sticky", {31'd0, err_unexp_o}, 32'd1); tick();
    end
    assert_reset();
    probe(); chk("unexp_clr", {31'd0, err_unexp_o}, 32'd0); tick();
    rst_n = 1'b1;

    // Reset while a transaction is outstanding; its late response is stray
    m0_req_i = 1'b1; s_gnt_i = 1'b1;
    probe(); tick();
    m0_req_i = 1'b0; s_gnt_i = 1'b0;
    assert_reset(); probe(); tick(); rst_n = 1'b1;
    s_rvalid_i = 1'b1;
    probe(); chk("stale_no_rvld", {31'd0, m0_rvalid_o}, 32'd0); tick();
    s_rvalid_i = 1'b0;
    probe(); chk("stale_err", {31'd0, err_unexp_o}, 32'd1); tick();
    assert_reset(); probe(); tick(); rst_n = 1'b1;

    // Randomized traffic with occasional reset
    e_gnt0 = 1'b0; e_gnt1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        probe(); tick();
        rst_n = 1'b1;
      end
      drive_rand();
      probe();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_data_arbiter.md
ZERORISCY_DATA_ARBITER -- requirements
Module: zeroriscy_data_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of granted-but-unanswered slave transactions (range 1..4).
REQ-002 SHALL have port clk  in  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_req_i / m1_req_i  in  1  request from core LSU (m0) / debug-DMA master (m1).
REQ-005 SHALL have ports m0_gnt_o / m1_gnt_o  out  1  address-phase grant per master.
REQ-006 SHALL have ports m0_addr_i / m1_addr_i  in  32  byte address per master.
REQ-007 SHALL have ports m0_we_i / m1_we_i  in  1  write enable; m0_be_i / m1_be_i  in  4  byte enables.
REQ-008 SHALL have ports m0_wdata_i / m1_wdata_i  in  32  write data per master.
REQ-009 SHALL have ports m0_rvalid_o / m1_rvalid_o  out  1  response valid per master; m_rdata_o  out  32  shared read data.
REQ-010 SHALL have ports s_req_o  out  1; s_addr_o  out  32; s_we_o  out  1; s_be_o  out  4; s_wdata_o  out  32  (slave address phase).
REQ-011 SHALL have ports s_gnt_i  in  1; s_rvalid_i  in  1; s_rdata_i  in  32  (slave grant and response).
REQ-012 SHALL have port err_unexp_o  out  1  sticky flag: slave response received with nothing outstanding.

Function
REQ-013 SHALL drive s_req_o combinationally (zero latency) when an eligible master requests and outstanding count < MAX_OUTSTANDING.
REQ-014 SHALL drive s_addr_o/s_we_o/s_be_o/s_wdata_o from the selected master; m0 values when no master is selected.
REQ-015 SHALL assert mN_gnt_o = s_gnt_i AND s_req_o AND selected master == N; the other master's gnt SHALL be 0.
REQ-016 SHALL hold the selection: if s_req_o=1 and s_gnt_i=0 at a clock edge, the same master SHALL remain selected next cycle regardless of priority (masters keep req stable until gnt).
REQ-017 SHALL push the selected master id into an owner FIFO of depth MAX_OUTSTANDING on every s_req_o AND s_gnt_i cycle.
REQ-018 SHALL pop the FIFO head on every s_rvalid_i and assert mH_rvalid_o in the same cycle for head owner H; m_rdata_o = s_rdata_i always.
REQ-019 SHALL handle simultaneous push and pop in one cycle with count unchanged and order preserved.
REQ-020 SHALL block new grants when count == MAX_OUTSTANDING, even if s_rvalid_i is high that cycle (no bypass).
REQ-021 SHALL, on s_rvalid_i with count == 0, drive no mN_rvalid_o, leave count at 0, and set err_unexp_o until reset.
REQ-022 SHALL wrap FIFO read/write pointers modulo MAX_OUTSTANDING.
REQ-023 SHALL not select a master whose req is low; with no requests s_req_o = 0.

Reset
REQ-024 SHALL, while rst_n=0, clear count, FIFO pointers, hold state and err_unexp_o; all gnt/rvalid outputs 0; round-robin last-granted pointer = m1.
REQ-025 SHALL discard outstanding transactions on reset mid-operation; responses arriving after reset release SHALL raise err_unexp_o.

Configuration
REQ-026 SHALL, with ZERORISCY_ARB_RR_EN defined, arbitrate round-robin: on contention grant the master not last granted; last-granted pointer updates on each grant.
REQ-027 SHALL, without ZERORISCY_ARB_RR_EN, use fixed priority: m0 always wins contention; no last-granted pointer is implemented.

Verification
REQ-028 SHALL cover: m0 req addr 0x100 read, s_gnt same cycle, s_rvalid 2 cycles later rdata 0xDEADBEEF -> m0_gnt 1 cycle, m0_rvalid with 0xDEADBEEF, m1_rvalid 0.
REQ-029 SHALL cover: both req continuously, s_gnt always 1, s_rvalid 1 cycle later -> RR_EN: grants alternate m0,m1,m0,m1; without: m0 every cycle, m1 never.
REQ-030 SHALL cover: m1 selected, s_gnt low 3 cycles while m0 raises req -> s_addr stays m1's, m1_gnt on 4th cycle, m0 granted afterwards.
REQ-031 SHALL cover: MAX_OUTSTANDING=2, two grants, no rvalid -> s_req_o 0 on third request; one rvalid -> grant resumes next cycle.
REQ-032 SHALL cover: s_rvalid with count 0 -> err_unexp_o 1 and stays 1; rst_n low -> 0.
REQ-033 SHALL cover: m0 grant then m1 grant, responses in order -> m0_rvalid then m1_rvalid; push+pop same cycle keeps count 1.
